// File: rtl/lm75a_temp_bcd.sv
// lm75a_temp_bcd
// Converts the LM75A 11-bit two's complement temperature field (data_in[15:5],
// LSB = 0.125 degC) into sign + 3 integer BCD digits + 3 fractional BCD digits.
// A new conversion starts whenever the temperature field differs from the
// last converted value. The integer part goes through an 8-step sequential
// double-dabble. The 3 fractional bits go through a small lookup table.
// All outputs are registered.

module lm75a_temp_bcd (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   output logic        neg,
   output logic [11:0] bcd_int,
   output logic [11:0] bcd_frac,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] hold_q, hold_d;      // temperature field being converted
   logic [10:0] last_q, last_d;      // temperature field of the last result
   logic [19:0] sh_q, sh_d;          // {hundreds, tens, ones, binary[7:0]}
   logic [2:0]  frac_q, frac_d;      // eighths of a degree
   logic        sgn_q, sgn_d;
   logic [2:0]  cnt_q, cnt_d;        // double-dabble iteration counter
   logic        neg_q, neg_d;
   logic [11:0] int_q, int_d;
   logic [11:0] fout_q, fout_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        sgn_s;
   logic [10:0] mag_s;
   logic        unused_low_s;

   // Add 3 to a BCD nibble that would overflow past 9 after doubling
   function automatic logic [3:0] add3(input logic [3:0] n);
      if (n >= 4'd5) begin
         return n + 4'd3;
      end else begin
         return n;
      end
   endfunction

   // One double-dabble iteration: correct all BCD nibbles, then shift left
   function automatic logic [19:0] dabble_step(input logic [19:0] s);
      logic [19:0] t;
      t = {add3(s[19:16]), add3(s[15:12]), add3(s[11:8]), s[7:0]};
      return {t[18:0], 1'b0};
   endfunction

   // Eighths of a degree to three BCD decimal digits
   function automatic logic [11:0] frac_bcd(input logic [2:0] f);
      case (f)
         3'd0:    return 12'h000;
         3'd1:    return 12'h125;
         3'd2:    return 12'h250;
         3'd3:    return 12'h375;
         3'd4:    return 12'h500;
         3'd5:    return 12'h625;
         3'd6:    return 12'h750;
         3'd7:    return 12'h875;
         default: return 12'h000;
      endcase
   endfunction

   // The low five bits of the reader word carry no temperature information
   assign unused_low_s = ^data_in[4:0];

   // Sign and magnitude of the held field; -1024 maps to 1024, which fits in 11 bits
   assign sgn_s = hold_q[10];
   assign mag_s = sgn_s ? (11'd0 - hold_q) : hold_q;

   // Next-state and datapath control for the conversion sequence
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      sh_d    = sh_q;
      frac_d  = frac_q;
      sgn_d   = sgn_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      int_d   = int_q;
      fout_d  = fout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (data_in[15:5] != last_q) begin
               hold_d  = data_in[15:5];
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            sgn_d   = sgn_s;
            frac_d  = mag_s[2:0];
            sh_d    = {12'd0, mag_s[10:3]};
            cnt_d   = 3'd0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            sh_d = dabble_step(sh_q);
            if (cnt_q == 3'd7) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_DONE: begin
            neg_d   = sgn_q;
            int_d   = sh_q[19:8];
            fout_d  = frac_bcd(frac_q);
            last_d  = hold_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any conversion in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hold_q  <= 11'd0;
         last_q  <= 11'd0;
         sh_q    <= 20'd0;
         frac_q  <= 3'd0;
         sgn_q   <= 1'b0;
         cnt_q   <= 3'd0;
         neg_q   <= 1'b0;
         int_q   <= 12'd0;
         fout_q  <= 12'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         sh_q    <= sh_d;
         frac_q  <= frac_d;
         sgn_q   <= sgn_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         int_q   <= int_d;
         fout_q  <= fout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign neg      = neg_q;
   assign bcd_int  = int_q;
   assign bcd_frac = fout_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_lm75a_temp_bcd.sv
// Directed testbench for lm75a_temp_bcd with hand-computed expected values.

module tb_lm75a_temp_bcd;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic        neg;
   logic [11:0] bcd_int;
   logic [11:0] bcd_frac;
   logic        busy;
   logic        done;

   int n_tests;
   int n_fail;

   lm75a_temp_bcd dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .neg      (neg),
      .bcd_int  (bcd_int),
      .bcd_frac (bcd_frac),
      .busy     (busy),
      .done     (done)
   );

   // 50 MHz clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Tick until done is seen or the budget runs out; n = ticks taken, -1 on timeout
   task automatic wait_done(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (done === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // Drive a word, let the compare edge occur, then check latency and result
   task automatic convert(input string tag, input logic [15:0] w,
                          input logic exp_neg, input logic [11:0] exp_int,
                          input logic [11:0] exp_frac);
      int n;
      data_in = w;
      tick();                         // edge E
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      wait_done(30, n);
      check({tag, " latency"}, n, 32'd10);
      check({tag, " neg"}, {31'd0, neg}, {31'd0, exp_neg});
      check({tag, " int"}, {20'd0, bcd_int}, {20'd0, exp_int});
      check({tag, " frac"}, {20'd0, bcd_frac}, {20'd0, exp_frac});
      tick();
      check({tag, " done width"}, {31'd0, done}, 32'd0);
      check({tag, " busy end"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int pulses;
      int d1;
      int d2;
      logic        n1;
      logic        n2;
      logic [11:0] i1;
      logic [11:0] i2;
      logic [11:0] f1;
      logic [11:0] f2;

      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      data_in = 16'h0000;
      tick();
      tick();
      rst = 1'b0;

      // Reset state and idle with zero input
      check("rst neg", {31'd0, neg}, 32'd0);
      check("rst int", {20'd0, bcd_int}, 32'd0);
      check("rst frac", {20'd0, bcd_frac}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      check("idle zero activity", pulses, 32'd0);

      convert("p125", 16'h7D00, 1'b0, 12'h125, 12'h000);
      convert("p25_5", 16'h1980, 1'b0, 12'h025, 12'h500);

      // Change only in ignored bits: no conversion
      data_in = 16'h1981;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      check("low bits ignored", pulses, 32'd0);
      check("low bits hold int", {20'd0, bcd_int}, 32'h025);

      convert("m0_125", 16'hFFE0, 1'b1, 12'h000, 12'h125);
      convert("m128", 16'h8000, 1'b1, 12'h128, 12'h000);

      // Mid-conversion change: -25.0 then +12.5 written right after E+4
      data_in = 16'hE700;
      tick();                         // edge E
      d1 = -1; d2 = -1;
      n1 = 1'b0; n2 = 1'b0; i1 = 12'd0; i2 = 12'd0; f1 = 12'd0; f2 = 12'd0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 4) data_in = 16'h0C80;
         if (done === 1'b1) begin
            if (d1 < 0) begin
               d1 = k; n1 = neg; i1 = bcd_int; f1 = bcd_frac;
            end else if (d2 < 0) begin
               d2 = k; n2 = neg; i2 = bcd_int; f2 = bcd_frac;
            end else begin
               d2 = 99;
            end
         end
      end
      check("mid first latency", d1, 32'd10);
      check("mid first neg", {31'd0, n1}, 32'd1);
      check("mid first int", {20'd0, i1}, 32'h025);
      check("mid first frac", {20'd0, f1}, 32'h000);
      check("mid second latency", d2, 32'd21);
      check("mid second neg", {31'd0, n2}, 32'd0);
      check("mid second int", {20'd0, i2}, 32'h012);
      check("mid second frac", {20'd0, f2}, 32'h500);

      // Reset at E+5 of a conversion abandons it
      data_in = 16'h7D00;
      tick();                         // edge E
      pulses = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      rst = 1'b1;
      tick();
      if (done === 1'b1) pulses++;
      rst = 1'b0;
      check("abort no done", pulses, 32'd0);
      check("abort neg", {31'd0, neg}, 32'd0);
      check("abort int", {20'd0, bcd_int}, 32'd0);
      check("abort frac", {20'd0, bcd_frac}, 32'd0);
      check("abort busy", {31'd0, busy}, 32'd0);
      convert("reconv", 16'h7D00, 1'b0, 12'h125, 12'h000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lm75a_temp_bcd.md
# lm75a_temp_bcd

Downstream stage of the LM75A I2C reader: takes the 16-bit temperature register value the reader presents and converts it to signed decimal BCD for the display driver. It watches the reader's data bus, starts a sequential double-dabble conversion whenever the temperature field changes, and presents the result as sign, three integer BCD digits and three fractional BCD digits. It raises a one-cycle `done` strobe for each new result.

## Interface
- No parameters; the data format is fixed to LM75A (11-bit two's complement in [15:5], LSB = 0.125 °C).
- `clk`  in  1  system clock, 50 MHz, same clock as the I2C reader.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  16  raw temperature word from the I2C reader; bits [4:0] are ignored.
- `neg`  out  1  1 = temperature negative.
- `bcd_int`  out  12  integer part, {hundreds, tens, ones}, each 4-bit BCD, range 000..128.
- `bcd_frac`  out  12  fractional part, {tenths, hundredths, thousandths}, each 4-bit BCD, one of 000/125/250/375/500/625/750/875.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; outputs updated in the same cycle.

## Operation
- Reset forces every output to 0 and sets `last_q` to 0 (the stored [15:5] of the last converted word). State goes to IDLE, and any conversion in progress is abandoned. After reset, `data_in` = 0 needs no conversion.
- State machine: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - IDLE: when `data_in[15:5] != last_q`, capture `data_in[15:5]` into `hold_q`, set `busy`, go to LOAD. Otherwise stay in IDLE.
  - LOAD: compute `sgn = hold_q[10]` and `mag = sgn ? -hold_q : hold_q`, both 11-bit unsigned. The value −1024 gives `mag` = 1024, which fits. Load a 20-bit shift register with {12'b0, mag[10:3]}, store `mag[2:0]`, clear the iteration counter, go to SHIFT.
  - SHIFT: 8 iterations, one per clock. In each iteration, first add 3 to every BCD nibble ≥ 5, then shift the whole register left by 1. After the 8th iteration go to DONE.
  - DONE: set `neg` = `sgn`. Set `bcd_int` = shift register [19:8]. Set `bcd_frac` from a lookup on `mag[2:0]`: 0→000, 1→125, 2→250, 3→375, 4→500, 5→625, 6→750, 7→875. Set `last_q` = `hold_q`, pulse `done`, clear `busy`, go to IDLE.
- Zero magnitude with the sign bit clear displays 000.000 with `neg` = 0. A negative value always has `mag` ≠ 0, so the block never produces a negative zero.
- `data_in` is not sampled while `busy` is high. On return to IDLE it is compared again, so the final settled value is always converted. At most one back-to-back conversion follows a change made mid-conversion.
- A change only in `data_in[4:0]` triggers no conversion and no `done` pulse.
- Outputs hold their last result between conversions.

## Timing
- Let edge E be the edge at which IDLE samples `data_in[15:5] != last_q`.
  - `busy` is high from E+1.
  - LOAD occurs at E+1, SHIFT at E+2..E+9, DONE at E+10.
  - New outputs and `done` = 1 are visible after edge E+10, for exactly one cycle. `busy` is low after edge E+10.
- Fixed latency of 10 cycles, change to result. The earliest next compare is at edge E+11.
- Conversion time of 0.2 µs is far shorter than the reader's 1 s update period, so no update is lost in normal use.
- Reset asserted in any state takes effect on the next edge. The outputs return to 0 and `done` is not pulsed.
- No combinational path from `data_in` to any output.

## Test plan
- Reset, then hold `data_in` = 0x0000 for 50 cycles -> `done` never pulses, all outputs 0, `busy` 0.
- `data_in` = 0x7D00 (+125.0) -> exactly 10 cycles after detection: `done` = 1, `neg` = 0, `bcd_int` = 0x125, `bcd_frac` = 0x000.
- `data_in` = 0x1980 (+25.5), then 0x1981 -> first word gives `bcd_int` = 0x025, `bcd_frac` = 0x500. The second word produces no `done` pulse.
- `data_in` = 0xFFE0 (−0.125) -> `neg` = 1, `bcd_int` = 0x000, `bcd_frac` = 0x125. Then `data_in` = 0x8000 (−128.0) -> `neg` = 1, `bcd_int` = 0x128, `bcd_frac` = 0x000.
- Drive `data_in` from 0xE700 (−25.0) to 0x0C80 (+12.5) at E+4 of the first conversion -> first `done` shows −025.000. A second conversion starts at E+11, and its `done` shows +012.500.
- Assert `rst` at E+5 of a conversion for 0x7D00 -> no `done` pulse, outputs 0. After release, 0x7D00 still present is reconverted, and 125.000 appears 10 cycles after detection.
